// File: rtl/round_timer_ctrl_pkg.sv
// Shared types and constants for the round countdown timer: state encoding,
// flash band codes, band thresholds and small conversion helpers.
package round_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam logic [1:0] BAND_LT10 = 2'd0;
    localparam logic [1:0] BAND_GE10 = 2'd1;
    localparam logic [1:0] BAND_GE20 = 2'd2;
    localparam logic [1:0] BAND_GE30 = 2'd3;

    localparam logic [5:0] BAND_TH_10 = 6'd10;
    localparam logic [5:0] BAND_TH_20 = 6'd20;
    localparam logic [5:0] BAND_TH_30 = 6'd30;

    function automatic logic [1:0] band_of(input logic [5:0] s);
        if (s >= BAND_TH_30) begin
            return BAND_GE30;
        end else if (s >= BAND_TH_20) begin
            return BAND_GE20;
        end else if (s >= BAND_TH_10) begin
            return BAND_GE10;
        end else begin
            return BAND_LT10;
        end
    endfunction

    // Packed {tens, ones}; values up to 63 keep tens within one digit.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

endpackage

// File: rtl/round_timer_ctrl_if.sv
// Control pulses and status outputs of the round timer, bundled for the
// game controller (master) and the timer block (slave).
interface round_timer_ctrl_if;

    logic       start;
    logic       stop;
    logic       penalty;
    logic [5:0] secs;
    logic [3:0] secs_tens;
    logic [3:0] secs_ones;
    logic       running;
    logic       expired;
    logic       timed_out;
    logic [1:0] band;
    logic       flash;

    modport master (
        output start, stop, penalty,
        input  secs, secs_tens, secs_ones, running, expired, timed_out, band, flash
    );

    modport slave (
        input  start, stop, penalty,
        output secs, secs_tens, secs_ones, running, expired, timed_out, band, flash
    );

endinterface

// File: rtl/round_timer_ctrl_flash_gen.sv
// Red-LED flash window generator: a period counter whose length follows the
// current band, restarted whenever the band changes and parked at 0 when idle.
module round_flash_gen
    import round_timer_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 50_000_000,
    parameter int FLASH_ON_TICKS = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] band,
    output logic       flash
);

    localparam int               PER_W   = $clog2(2 * TICKS_PER_SEC);
    localparam logic [PER_W-1:0] PER_MAX = PER_W'(2 * TICKS_PER_SEC - 1);
    localparam logic [PER_W-1:0] ON_LEN  = PER_W'(FLASH_ON_TICKS);

    logic [PER_W-1:0] cnt_r;
    logic [PER_W-1:0] last_s;
    logic [1:0]       band_r;

    // Last count of the current period; 2*TICKS_PER_SEC is a multiple of 8,
    // so shifting the all-period maximum yields exact period-1 values.
    always_comb begin
        last_s = PER_MAX;
        case (band)
            BAND_GE30: last_s = PER_MAX;
            BAND_GE20: last_s = PER_MAX >> 1;
            BAND_GE10: last_s = PER_MAX >> 2;
            BAND_LT10: last_s = PER_MAX >> 3;
            default:   last_s = PER_MAX;
        endcase
    end

    // Period counter with restart on band change or while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= '0;
            band_r <= BAND_LT10;
        end else begin
            band_r <= band;
            if (!enable || (band != band_r)) begin
                cnt_r <= '0;
            end else if (cnt_r >= last_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + PER_W'(1);
            end
        end
    end

    assign flash = enable && (cnt_r < ON_LEN);

endmodule

// File: rtl/round_timer_ctrl.sv
// Per-round countdown scheduler: loads the round time, counts seconds down,
// applies penalties, freezes on a win and drives the flash schedule.
module round_timer_ctrl
    import round_timer_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 50_000_000,
    parameter int ROUND_SECS     = 40,
    parameter int PENALTY_SECS   = 2,
    parameter int FLASH_ON_TICKS = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    round_timer_ctrl_if.slave  bus
);

    localparam int                TICK_W    = $clog2(TICKS_PER_SEC);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [5:0]        ROUND_VAL = 6'(ROUND_SECS);
    localparam logic [7:0]        PEN_VAL   = 8'(PENALTY_SECS);

    state_e            state_r;
    logic [5:0]        secs_r;
    logic [TICK_W-1:0] tick_r;
    logic              running_r;
    logic              expired_r;
    logic              timed_out_r;

    logic              tick_wrap_s;
    logic [7:0]        dec_s;
    logic [5:0]        next_secs_s;
    logic [7:0]        bcd_s;
    logic              flash_s;

    assign tick_wrap_s = (state_r == RUN) && (tick_r == TICK_LAST);

    // Seconds to remove this cycle and the saturated result.
    always_comb begin
        dec_s       = 8'd0;
        next_secs_s = secs_r;
        if (tick_wrap_s && bus.penalty) begin
            dec_s = PEN_VAL + 8'd1;
        end else if (tick_wrap_s) begin
            dec_s = 8'd1;
        end else if (bus.penalty) begin
            dec_s = PEN_VAL;
        end else begin
            dec_s = 8'd0;
        end
        if ({2'b00, secs_r} > dec_s) begin
            next_secs_s = secs_r - dec_s[5:0];
        end else begin
            next_secs_s = 6'd0;
        end
    end

    // Main FSM: start overrides everything; in RUN expiry beats stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            secs_r      <= 6'd0;
            tick_r      <= '0;
            running_r   <= 1'b0;
            expired_r   <= 1'b0;
            timed_out_r <= 1'b0;
        end else if (bus.start) begin
            state_r     <= RUN;
            secs_r      <= ROUND_VAL;
            tick_r      <= '0;
            running_r   <= 1'b1;
            expired_r   <= 1'b0;
            timed_out_r <= 1'b0;
        end else begin
            expired_r <= 1'b0;
            case (state_r)
                RUN: begin
                    tick_r <= tick_wrap_s ? '0 : tick_r + TICK_W'(1);
                    secs_r <= next_secs_s;
                    if (next_secs_s == 6'd0) begin
                        state_r     <= EXPIRED;
                        running_r   <= 1'b0;
                        expired_r   <= 1'b1;
                        timed_out_r <= 1'b1;
                    end else if (bus.stop) begin
                        state_r   <= HOLD;
                        running_r <= 1'b0;
                    end else begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end
                end
                IDLE, HOLD, EXPIRED: begin
                    state_r   <= state_r;
                    running_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    round_flash_gen #(
        .TICKS_PER_SEC  (TICKS_PER_SEC),
        .FLASH_ON_TICKS (FLASH_ON_TICKS)
    ) u_flash (
        .clk    (clk),
        .reset  (reset),
        .enable (running_r),
        .band   (bus.band),
        .flash  (flash_s)
    );

    assign bcd_s         = to_bcd(secs_r);
    assign bus.secs      = secs_r;
    assign bus.secs_tens = bcd_s[7:4];
    assign bus.secs_ones = bcd_s[3:0];
    assign bus.running   = running_r;
    assign bus.expired   = expired_r;
    assign bus.timed_out = timed_out_r;
    assign bus.band      = band_of(secs_r);
    assign bus.flash     = flash_s;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with a fast second (8 clocks),
// 12-second rounds, 2-second penalty and 1-clock flash window.
module tb_round_timer_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   fl_cnt;
    int   bad_hold;

    round_timer_ctrl_if bus();

    round_timer_ctrl #(
        .TICKS_PER_SEC  (8),
        .ROUND_SECS     (12),
        .PENALTY_SECS   (2),
        .FLASH_ON_TICKS (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advance(input int k);
        while (cyc < k) step();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
    endtask

    task automatic count_flash(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.flash === 1'b1) c++;
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.penalty = 1'b0;
        reset = 1'b1;
        step(); step();
        check("rst_secs", 32'(bus.secs), 32'd0);
        check("rst_running", 32'(bus.running), 32'd0);
        check("rst_expired", 32'(bus.expired), 32'd0);
        check("rst_timed_out", 32'(bus.timed_out), 32'd0);
        check("rst_band", 32'(bus.band), 32'd0);
        check("rst_flash", 32'(bus.flash), 32'd0);
        reset = 1'b0;
        step();

        // Round 1: plain countdown, BCD, band and flash cadence.
        do_start();
        check("start_running", 32'(bus.running), 32'd1);
        check("start_secs", 32'(bus.secs), 32'd12);
        check("start_tens", 32'(bus.secs_tens), 32'd1);
        check("start_ones", 32'(bus.secs_ones), 32'd2);
        check("start_band", 32'(bus.band), 32'd1);
        check("start_flash", 32'(bus.flash), 32'd1);
        advance(7);
        check("pre_dec_secs", 32'(bus.secs), 32'd12);
        advance(8);
        check("first_dec_secs", 32'(bus.secs), 32'd11);
        check("first_dec_ones", 32'(bus.secs_ones), 32'd1);
        count_flash(8, fl_cnt);
        check("band1_flash_count", 32'(fl_cnt), 32'd2);
        advance(24);
        check("sec9_secs", 32'(bus.secs), 32'd9);
        check("sec9_band", 32'(bus.band), 32'd0);
        check("sec9_tens", 32'(bus.secs_tens), 32'd0);
        check("sec9_flash", 32'(bus.flash), 32'd0);
        step();
        check("band0_restart_flash", 32'(bus.flash), 32'd1);
        count_flash(8, fl_cnt);
        check("band0_flash_count", 32'(fl_cnt), 32'd4);
        advance(95);
        check("pre_exp_secs", 32'(bus.secs), 32'd1);
        check("pre_exp_expired", 32'(bus.expired), 32'd0);
        advance(96);
        check("exp_secs", 32'(bus.secs), 32'd0);
        check("exp_expired", 32'(bus.expired), 32'd1);
        check("exp_timed_out", 32'(bus.timed_out), 32'd1);
        check("exp_running", 32'(bus.running), 32'd0);
        step();
        check("exp_pulse_end", 32'(bus.expired), 32'd0);
        advance(110);
        check("exp_hold_timed_out", 32'(bus.timed_out), 32'd1);
        check("exp_hold_flash", 32'(bus.flash), 32'd0);

        // Round 2: penalty alone at secs=5.
        do_start();
        check("restart_timed_out", 32'(bus.timed_out), 32'd0);
        advance(57);
        bus.penalty = 1'b1; step(); bus.penalty = 1'b0;
        check("pen_secs5", 32'(bus.secs), 32'd3);

        // Round 3: penalty on tick wrap at secs=5, then penalty at secs=1.
        do_start();
        advance(63);
        check("wrap_pre_secs", 32'(bus.secs), 32'd5);
        bus.penalty = 1'b1; step(); bus.penalty = 1'b0;
        check("pen_wrap_secs", 32'(bus.secs), 32'd2);
        check("pen_wrap_running", 32'(bus.running), 32'd1);
        advance(73);
        check("pen1_pre_secs", 32'(bus.secs), 32'd1);
        bus.penalty = 1'b1; step(); bus.penalty = 1'b0;
        check("pen1_secs", 32'(bus.secs), 32'd0);
        check("pen1_expired", 32'(bus.expired), 32'd1);
        check("pen1_timed_out", 32'(bus.timed_out), 32'd1);
        step();
        check("pen1_pulse_end", 32'(bus.expired), 32'd0);

        // Round 4: stop at secs=7, hold, penalty ignored in HOLD.
        do_start();
        advance(40);
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        check("stop_running", 32'(bus.running), 32'd0);
        check("stop_secs", 32'(bus.secs), 32'd7);
        bad_hold = 0;
        for (int i = 0; i < 50; i++) begin
            bus.penalty = (i == 10) ? 1'b1 : 1'b0;
            step();
            if (bus.secs !== 6'd7 || bus.flash !== 1'b0 || bus.expired !== 1'b0) bad_hold++;
        end
        bus.penalty = 1'b0;
        check("hold_bad_cycles", 32'(bad_hold), 32'd0);
        check("hold_timed_out", 32'(bus.timed_out), 32'd0);
        do_start();
        check("hold_restart_secs", 32'(bus.secs), 32'd12);
        check("hold_restart_running", 32'(bus.running), 32'd1);

        // Same round: stop on the final decrement loses to expiry.
        advance(95);
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        check("stop_exp_expired", 32'(bus.expired), 32'd1);
        check("stop_exp_timed_out", 32'(bus.timed_out), 32'd1);
        check("stop_exp_running", 32'(bus.running), 32'd0);

        // start beats stop and penalty in the same cycle.
        bus.start = 1'b1; bus.stop = 1'b1; bus.penalty = 1'b1;
        step();
        bus.start = 1'b0; bus.stop = 1'b0; bus.penalty = 1'b0;
        cyc = 0;
        check("start_prio_secs", 32'(bus.secs), 32'd12);
        check("start_prio_running", 32'(bus.running), 32'd1);
        check("start_prio_timed_out", 32'(bus.timed_out), 32'd0);

        // Reset mid-round.
        advance(30);
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_rst_secs", 32'(bus.secs), 32'd0);
        check("mid_rst_running", 32'(bus.running), 32'd0);
        check("mid_rst_flash", 32'(bus.flash), 32'd0);
        check("mid_rst_band", 32'(bus.band), 32'd0);
        check("mid_rst_timed_out", 32'(bus.timed_out), 32'd0);
        step(); step();
        check("post_rst_expired", 32'(bus.expired), 32'd0);
        check("post_rst_running", 32'(bus.running), 32'd0);
        check("post_rst_secs", 32'(bus.secs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
